axi4_burst_master: RTL and testbench



---
 rtl/axi4_burst_master_if.sv | 76 +++++++
 rtl/axi4_burst_master.sv | 198 +++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_master_if.sv
// AXI4 channel bundle between the burst master and a memory/MMIO responder.
interface axi4_burst_master_if #(
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
);
  logic                        bits_aw_valid;
  logic                        bits_aw_ready;
  logic [AXI_ID_WIDTH-1:0]     bits_aw_bits_id;
  logic [AXI_ADDR_WIDTH-1:0]   bits_aw_bits_addr;
  logic [7:0]                  bits_aw_bits_len;
  logic [2:0]                  bits_aw_bits_size;
  logic [1:0]                  bits_aw_bits_burst;
  logic                        bits_aw_bits_lock;
  logic [3:0]                  bits_aw_bits_cache;
  logic [2:0]                  bits_aw_bits_prot;
  logic [3:0]                  bits_aw_bits_qos;

  logic                        bits_ar_valid;
  logic                        bits_ar_ready;
  logic [AXI_ID_WIDTH-1:0]     bits_ar_bits_id;
  logic [AXI_ADDR_WIDTH-1:0]   bits_ar_bits_addr;
  logic [7:0]                  bits_ar_bits_len;
  logic [2:0]                  bits_ar_bits_size;
  logic [1:0]                  bits_ar_bits_burst;
  logic                        bits_ar_bits_lock;
  logic [3:0]                  bits_ar_bits_cache;
  logic [2:0]                  bits_ar_bits_prot;
  logic [3:0]                  bits_ar_bits_qos;

  logic                        bits_w_valid;
  logic                        bits_w_ready;
  logic [AXI_DATA_WIDTH-1:0]   bits_w_bits_data;
  logic [AXI_DATA_WIDTH/8-1:0] bits_w_bits_strb;
  logic                        bits_w_bits_last;

  logic                        bits_b_valid;
  logic                        bits_b_ready;
  logic [AXI_ID_WIDTH-1:0]     bits_b_bits_id;
  logic [1:0]                  bits_b_bits_resp;

  logic                        bits_r_valid;
  logic                        bits_r_ready;
  logic [AXI_ID_WIDTH-1:0]     bits_r_bits_id;
  logic [AXI_DATA_WIDTH-1:0]   bits_r_bits_data;
  logic [1:0]                  bits_r_bits_resp;
  logic                        bits_r_bits_last;

  modport master (
    output bits_aw_valid, bits_aw_bits_id, bits_aw_bits_addr, bits_aw_bits_len,
           bits_aw_bits_size, bits_aw_bits_burst, bits_aw_bits_lock, bits_aw_bits_cache,
           bits_aw_bits_prot, bits_aw_bits_qos,
           bits_ar_valid, bits_ar_bits_id, bits_ar_bits_addr, bits_ar_bits_len,
           bits_ar_bits_size, bits_ar_bits_burst, bits_ar_bits_lock, bits_ar_bits_cache,
           bits_ar_bits_prot, bits_ar_bits_qos,
           bits_w_valid, bits_w_bits_data, bits_w_bits_strb, bits_w_bits_last,
           bits_b_ready, bits_r_ready,
    input  bits_aw_ready, bits_ar_ready, bits_w_ready,
           bits_b_valid, bits_b_bits_id, bits_b_bits_resp,
           bits_r_valid, bits_r_bits_id, bits_r_bits_data, bits_r_bits_resp, bits_r_bits_last
  );

  modport slave (
    input  bits_aw_valid, bits_aw_bits_id, bits_aw_bits_addr, bits_aw_bits_len,
           bits_aw_bits_size, bits_aw_bits_burst, bits_aw_bits_lock, bits_aw_bits_cache,
           bits_aw_bits_prot, bits_aw_bits_qos,
           bits_ar_valid, bits_ar_bits_id, bits_ar_bits_addr, bits_ar_bits_len,
           bits_ar_bits_size, bits_ar_bits_burst, bits_ar_bits_lock, bits_ar_bits_cache,
           bits_ar_bits_prot, bits_ar_bits_qos,
           bits_w_valid, bits_w_bits_data, bits_w_bits_strb, bits_w_bits_last,
           bits_b_ready, bits_r_ready,
    output bits_aw_ready, bits_ar_ready, bits_w_ready,
           bits_b_valid, bits_b_bits_id, bits_b_bits_resp,
           bits_r_valid, bits_r_bits_id, bits_r_bits_data, bits_r_bits_resp, bits_r_bits_last
  );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 burst initiator: one local command -> one AXI read
// or write burst -> one completion carrying the worst response and an error flag.
module axi4_burst_master #(
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]                  cmd_len,
  input  logic [2:0]                  cmd_size,
  input  logic [1:0]                  cmd_burst,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] wr_strb,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                        rd_last,
  output logic                        done_valid,
  input  logic                        done_ready,
  output logic [1:0]                  done_resp,
  output logic                        done_err,
  axi4_burst_master_if.master         axi4_mmio_0
);

  localparam logic [AXI_ID_WIDTH-1:0] ID_C     = AXI_ID[AXI_ID_WIDTH-1:0];
  localparam logic [2:0]              MAX_SIZE = 3'($clog2(AXI_DATA_WIDTH/8));

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_e;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                  len_q, len_d;
  logic [2:0]                  size_q, size_d;
  logic [1:0]                  burst_q, burst_d;
  logic [7:0]                  beat_cnt_q, beat_cnt_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        err_q, err_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        aw_valid_q, aw_valid_d;
  logic                        ar_valid_q, ar_valid_d;
  logic                        b_ready_q, b_ready_d;
  logic                        done_valid_q, done_valid_d;

  logic in_w, in_r, last_beat, illegal;

  assign in_w      = (state_q == W);
  assign in_r      = (state_q == R);
  assign last_beat = (beat_cnt_q == len_q);
  assign illegal   = (cmd_size > MAX_SIZE) || (cmd_burst == 2'b11) ||
                     ((cmd_burst == 2'b10) && !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // Next-state, field capture, beat counting and response accumulation.
  // Handshake-style outputs are decoded from the next state so they leave a flop.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    resp_d     = resp_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d     = cmd_addr;
          len_d      = cmd_len;
          size_d     = cmd_size;
          burst_d    = cmd_burst;
          beat_cnt_d = '0;
          resp_d     = '0;
          err_d      = 1'b0;
          if (illegal) begin
            state_d = DONE;
            resp_d  = 2'b10;
            err_d   = 1'b1;
          end else begin
            state_d = cmd_write ? AW : AR;
          end
        end
      end
      AW: if (aw_valid_q && axi4_mmio_0.bits_aw_ready) state_d = W;
      AR: if (ar_valid_q && axi4_mmio_0.bits_ar_ready) state_d = R;
      W: begin
        if (wr_valid && axi4_mmio_0.bits_w_ready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) state_d = B;
        end
      end
      B: begin
        if (b_ready_q && axi4_mmio_0.bits_b_valid) begin
          if (axi4_mmio_0.bits_b_bits_resp > resp_q) resp_d = axi4_mmio_0.bits_b_bits_resp;
          err_d   = err_q | (axi4_mmio_0.bits_b_bits_id != ID_C);
          state_d = DONE;
        end
      end
      R: begin
        if (axi4_mmio_0.bits_r_valid && rd_ready) begin
          if (axi4_mmio_0.bits_r_bits_resp > resp_q) resp_d = axi4_mmio_0.bits_r_bits_resp;
          err_d      = err_q | (axi4_mmio_0.bits_r_bits_id != ID_C) |
                       (axi4_mmio_0.bits_r_bits_last != last_beat);
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: if (done_valid_q && done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d  = (state_d == IDLE);
    aw_valid_d   = (state_d == AW);
    ar_valid_d   = (state_d == AR);
    b_ready_d    = (state_d == B);
    done_valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_cnt_q   <= '0;
      resp_q       <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      aw_valid_q   <= 1'b0;
      ar_valid_q   <= 1'b0;
      b_ready_q    <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beat_cnt_q   <= beat_cnt_d;
      resp_q       <= resp_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      aw_valid_q   <= aw_valid_d;
      ar_valid_q   <= ar_valid_d;
      b_ready_q    <= b_ready_d;
      done_valid_q <= done_valid_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign done_valid = done_valid_q;
  assign done_resp  = resp_q;
  assign done_err   = err_q;

  assign axi4_mmio_0.bits_aw_valid      = aw_valid_q;
  assign axi4_mmio_0.bits_aw_bits_id    = ID_C;
  assign axi4_mmio_0.bits_aw_bits_addr  = addr_q;
  assign axi4_mmio_0.bits_aw_bits_len   = len_q;
  assign axi4_mmio_0.bits_aw_bits_size  = size_q;
  assign axi4_mmio_0.bits_aw_bits_burst = burst_q;
  assign axi4_mmio_0.bits_aw_bits_lock  = 1'b0;
  assign axi4_mmio_0.bits_aw_bits_cache = 4'b0011;
  assign axi4_mmio_0.bits_aw_bits_prot  = 3'b000;
  assign axi4_mmio_0.bits_aw_bits_qos   = 4'b0000;

  assign axi4_mmio_0.bits_ar_valid      = ar_valid_q;
  assign axi4_mmio_0.bits_ar_bits_id    = ID_C;
  assign axi4_mmio_0.bits_ar_bits_addr  = addr_q;
  assign axi4_mmio_0.bits_ar_bits_len   = len_q;
  assign axi4_mmio_0.bits_ar_bits_size  = size_q;
  assign axi4_mmio_0.bits_ar_bits_burst = burst_q;
  assign axi4_mmio_0.bits_ar_bits_lock  = 1'b0;
  assign axi4_mmio_0.bits_ar_bits_cache = 4'b0011;
  assign axi4_mmio_0.bits_ar_bits_prot  = 3'b000;
  assign axi4_mmio_0.bits_ar_bits_qos   = 4'b0000;

  // Data paths are gated by state so nothing leaks out outside W/R or during reset.
  assign axi4_mmio_0.bits_w_valid     = in_w & wr_valid;
  assign wr_ready                     = in_w & axi4_mmio_0.bits_w_ready;
  assign axi4_mmio_0.bits_w_bits_data = in_w ? wr_data : '0;
  assign axi4_mmio_0.bits_w_bits_strb = in_w ? wr_strb : '0;
  assign axi4_mmio_0.bits_w_bits_last = in_w & last_beat;

  assign axi4_mmio_0.bits_b_ready = b_ready_q;

  assign rd_valid                 = in_r & axi4_mmio_0.bits_r_valid;
  assign axi4_mmio_0.bits_r_ready = in_r & rd_ready;
  assign rd_data                  = in_r ? axi4_mmio_0.bits_r_bits_data : '0;
  assign rd_last                  = in_r & last_beat;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master; the bench itself plays the AXI slave.
module tb_axi4_burst_master;
  localparam int unsigned IDW = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic [7:0]    wr_strb;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          done_valid, done_ready;
  logic [1:0]    done_resp;
  logic          done_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  axi4_burst_master_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  axi4_burst_master #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID(0)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp), .done_err(done_err),
    .axi4_mmio_0(bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    chk("cmd_ready", cmd_ready, 1);
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_done(input string tag, input logic [1:0] exp_resp, input logic exp_err);
    chk({tag, "_done_valid"}, done_valid, 1);
    chk({tag, "_done_resp"}, done_resp, exp_resp);
    chk({tag, "_done_err"}, done_err, exp_err);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk({tag, "_done_clear"}, done_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] rv_pat;
    logic [15:0] rr_pat;
    int          k;
    int          cyc;

    reset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0; done_ready = 0;
    bus.bits_aw_ready = 0; bus.bits_ar_ready = 0; bus.bits_w_ready = 0;
    bus.bits_b_valid = 0; bus.bits_b_bits_id = '0; bus.bits_b_bits_resp = '0;
    bus.bits_r_valid = 0; bus.bits_r_bits_id = '0; bus.bits_r_bits_data = '0;
    bus.bits_r_bits_resp = '0; bus.bits_r_bits_last = 0;

    // Reset values
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_aw_valid", bus.bits_aw_valid, 0);
    chk("rst_ar_valid", bus.bits_ar_valid, 0);
    chk("rst_b_ready", bus.bits_b_ready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_resp", done_resp, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_aw_addr", bus.bits_aw_bits_addr, 0);
    chk("rst_aw_cache", bus.bits_aw_bits_cache, 4'b0011);
    chk("rst_ar_cache", bus.bits_ar_bits_cache, 4'b0011);
    chk("rst_ar_lock", bus.bits_ar_bits_lock, 0);
    chk("rst_ar_prot", bus.bits_ar_bits_prot, 0);
    chk("rst_ar_qos", bus.bits_ar_bits_qos, 0);
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);

    // Write INCR len=3 size=3 at 0x8000_0000, OKAY response
    send_cmd(1'b1, 32'h8000_0000, 8'd3, 3'd3, 2'b01);
    chk("w1_aw_valid", bus.bits_aw_valid, 1);
    chk("w1_ar_valid", bus.bits_ar_valid, 0);
    chk("w1_aw_addr", bus.bits_aw_bits_addr, 32'h8000_0000);
    chk("w1_aw_len", bus.bits_aw_bits_len, 3);
    chk("w1_aw_size", bus.bits_aw_bits_size, 3);
    chk("w1_aw_burst", bus.bits_aw_bits_burst, 2'b01);
    chk("w1_aw_id", bus.bits_aw_bits_id, 0);
    chk("w1_cmd_ready", cmd_ready, 0);
    bus.bits_aw_ready = 1'b1;
    tick();
    bus.bits_aw_ready = 1'b0;
    chk("w1_aw_dropped", bus.bits_aw_valid, 0);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 64'hDEAD_BEEF_0000_0000 + 64'(i); wr_strb = 8'hFF;
      bus.bits_w_ready = 1'b1;
      #1;
      chk("w1_w_valid", bus.bits_w_valid, 1);
      chk("w1_wr_ready", wr_ready, 1);
      chk("w1_w_data", bus.bits_w_bits_data, 64'hDEAD_BEEF_0000_0000 + 64'(i));
      chk("w1_w_strb", bus.bits_w_bits_strb, 8'hFF);
      chk("w1_w_last", bus.bits_w_bits_last, (i == 3) ? 1 : 0);
      tick();
    end
    wr_valid = 1'b0; bus.bits_w_ready = 1'b0;
    chk("w1_b_ready", bus.bits_b_ready, 1);
    chk("w1_done_early", done_valid, 0);
    bus.bits_b_valid = 1'b1; bus.bits_b_bits_id = '0; bus.bits_b_bits_resp = 2'b00;
    tick();
    bus.bits_b_valid = 1'b0;
    chk("w1_b_ready_drop", bus.bits_b_ready, 0);
    finish_done("w1", 2'b00, 1'b0);

    // Read len=0, SLVERR
    send_cmd(1'b0, 32'h0000_1000, 8'd0, 3'd3, 2'b01);
    chk("r2_ar_valid", bus.bits_ar_valid, 1);
    chk("r2_aw_valid", bus.bits_aw_valid, 0);
    chk("r2_ar_addr", bus.bits_ar_bits_addr, 32'h0000_1000);
    chk("r2_ar_len", bus.bits_ar_bits_len, 0);
    bus.bits_ar_ready = 1'b1;
    tick();
    bus.bits_ar_ready = 1'b0;
    bus.bits_r_valid = 1'b1; bus.bits_r_bits_data = 64'h0123_4567_89AB_CDEF;
    bus.bits_r_bits_resp = 2'b10; bus.bits_r_bits_last = 1'b1; bus.bits_r_bits_id = '0;
    rd_ready = 1'b1;
    #1;
    chk("r2_rd_valid", rd_valid, 1);
    chk("r2_r_ready", bus.bits_r_ready, 1);
    chk("r2_rd_data", rd_data, 64'h0123_4567_89AB_CDEF);
    chk("r2_rd_last", rd_last, 1);
    tick();
    bus.bits_r_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("r2_no_more_beats", bus.bits_r_ready, 0);
    finish_done("r2", 2'b10, 1'b0);

    // Read len=7, early r_last on beat 5, gaps and backpressure
    send_cmd(1'b0, 32'h0000_2000, 8'd7, 3'd3, 2'b01);
    bus.bits_ar_ready = 1'b1;
    tick();
    bus.bits_ar_ready = 1'b0;
    rv_pat = 16'b1011_0110_1101_1011;
    rr_pat = 16'b1110_1011_0111_1101;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 200) begin
      bus.bits_r_valid     = rv_pat[cyc % 16];
      bus.bits_r_bits_data = 64'hC0DE_0000_0000_0000 + 64'(k);
      bus.bits_r_bits_last = (k == 5);
      bus.bits_r_bits_resp = 2'b00;
      rd_ready             = rr_pat[cyc % 16];
      #1;
      chk("r3_rd_valid", rd_valid, bus.bits_r_valid);
      if (bus.bits_r_valid && rd_ready) begin
        chk("r3_rd_data", rd_data, 64'hC0DE_0000_0000_0000 + 64'(k));
        chk("r3_rd_last", rd_last, (k == 7) ? 1 : 0);
        k++;
      end
      tick();
      cyc++;
    end
    bus.bits_r_valid = 1'b0; bus.bits_r_bits_last = 1'b0; rd_ready = 1'b0;
    chk("r3_beats", k, 8);
    finish_done("r3", 2'b00, 1'b1);

    // Write len=1 with aw_ready held off 10 cycles and wr_valid offered early
    send_cmd(1'b1, 32'h0000_3000, 8'd1, 3'd2, 2'b01);
    wr_valid = 1'b1; wr_data = 64'h5555; wr_strb = 8'h0F; bus.bits_w_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("w4_aw_valid", bus.bits_aw_valid, 1);
      chk("w4_aw_addr", bus.bits_aw_bits_addr, 32'h0000_3000);
      chk("w4_aw_len", bus.bits_aw_bits_len, 1);
      chk("w4_no_w_valid", bus.bits_w_valid, 0);
      chk("w4_no_wr_ready", wr_ready, 0);
      tick();
    end
    wr_valid = 1'b0;
    bus.bits_aw_ready = 1'b1;
    tick();
    bus.bits_aw_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w4_stall_w_valid", bus.bits_w_valid, 0);
      chk("w4_stall_b_ready", bus.bits_b_ready, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 64'hA000 + 64'(i);
      #1;
      chk("w4_w_valid", bus.bits_w_valid, 1);
      chk("w4_w_data", bus.bits_w_bits_data, 64'hA000 + 64'(i));
      chk("w4_w_strb", bus.bits_w_bits_strb, 8'h0F);
      chk("w4_w_last", bus.bits_w_bits_last, (i == 1) ? 1 : 0);
      tick();
    end
    wr_valid = 1'b0; bus.bits_w_ready = 1'b0;
    bus.bits_b_valid = 1'b1; bus.bits_b_bits_id = 4'h5; bus.bits_b_bits_resp = 2'b01;
    tick();
    bus.bits_b_valid = 1'b0; bus.bits_b_bits_id = '0; bus.bits_b_bits_resp = '0;
    finish_done("w4", 2'b01, 1'b1);

    // Illegal: size 4 on a 64-bit bus
    send_cmd(1'b1, 32'h0000_4000, 8'd0, 3'd4, 2'b01);
    chk("i5_aw_valid", bus.bits_aw_valid, 0);
    chk("i5_ar_valid", bus.bits_ar_valid, 0);
    chk("i5_cmd_ready", cmd_ready, 0);
    finish_done("i5", 2'b10, 1'b1);

    // Illegal: WRAP with len=2
    send_cmd(1'b0, 32'h0000_5000, 8'd2, 3'd3, 2'b10);
    chk("i6_aw_valid", bus.bits_aw_valid, 0);
    chk("i6_ar_valid", bus.bits_ar_valid, 0);
    finish_done("i6", 2'b10, 1'b1);

    // Write len=255, reset asserted on beat 100
    send_cmd(1'b1, 32'h0000_6000, 8'd255, 3'd3, 2'b01);
    chk("w7_aw_len", bus.bits_aw_bits_len, 255);
    bus.bits_aw_ready = 1'b1;
    tick();
    bus.bits_aw_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wr_valid = 1'b1; wr_data = 64'(i); wr_strb = 8'hFF; bus.bits_w_ready = 1'b1;
      #1;
      chk("w7_w_last", bus.bits_w_bits_last, 0);
      tick();
    end
    #1;
    chk("w7_beat100_w_valid", bus.bits_w_valid, 1);
    reset = 1'b1;
    tick();
    chk("w7_rst_w_valid", bus.bits_w_valid, 0);
    chk("w7_rst_wr_ready", wr_ready, 0);
    chk("w7_rst_w_data", bus.bits_w_bits_data, 0);
    chk("w7_rst_w_strb", bus.bits_w_bits_strb, 0);
    chk("w7_rst_w_last", bus.bits_w_bits_last, 0);
    chk("w7_rst_aw_valid", bus.bits_aw_valid, 0);
    chk("w7_rst_aw_addr", bus.bits_aw_bits_addr, 0);
    chk("w7_rst_aw_len", bus.bits_aw_bits_len, 0);
    chk("w7_rst_cmd_ready", cmd_ready, 0);
    chk("w7_rst_done_valid", done_valid, 0);
    chk("w7_rst_b_ready", bus.bits_b_ready, 0);
    wr_valid = 1'b0; bus.bits_w_ready = 1'b0;
    reset = 1'b0;
    tick();

    // Read len=0 after reset completes normally
    send_cmd(1'b0, 32'h0000_0040, 8'd0, 3'd3, 2'b01);
    chk("r8_ar_valid", bus.bits_ar_valid, 1);
    chk("r8_ar_addr", bus.bits_ar_bits_addr, 32'h0000_0040);
    bus.bits_ar_ready = 1'b1;
    tick();
    bus.bits_ar_ready = 1'b0;
    bus.bits_r_valid = 1'b1; bus.bits_r_bits_data = 64'hFEED_FACE_CAFE_F00D;
    bus.bits_r_bits_resp = 2'b00; bus.bits_r_bits_last = 1'b1; bus.bits_r_bits_id = '0;
    rd_ready = 1'b1;
    #1;
    chk("r8_rd_valid", rd_valid, 1);
    chk("r8_rd_data", rd_data, 64'hFEED_FACE_CAFE_F00D);
    chk("r8_rd_last", rd_last, 1);
    tick();
    bus.bits_r_valid = 1'b0; bus.bits_r_bits_last = 1'b0; rd_ready = 1'b0;
    finish_done("r8", 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
